pipe_stage_skid: RTL and testbench
==================================

Name: pipe_stage_skid

Overview:
- Parametrised inter-stage pipeline register for the pipelined CPU. It carries an instruction/data word plus a control-bit vector between two stages.
- Adds a valid/ready handshake, a 2-entry skid buffer so that in_ready is registered, and a synchronous flush that inserts a NOP bubble.
- Generalises the fixed 32-bit instruction / 11-bit control stage register.
- Intended for IF/ID, ID/EX and any later stage boundary.

Parameters:
- DATA_W, 32: width of the data/instruction word.
- CTRL_W, 11: width of the control vector.
- NOP_DATA, 32'hD503201F: data value presented while the stage is empty or flushed. Only the low DATA_W bits are used.

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  synchronous, active-high reset
- flush  input  1  synchronous kill of all held entries; bubble inserted
- in_valid  input  1  upstream offers a beat
- in_ready  output  1  registered; stage can accept a beat this cycle
- in_data  input  DATA_W  upstream data word
- in_ctrl  input  CTRL_W  upstream control bits
- out_valid  output  1  main register holds a live beat
- out_ready  input  1  downstream accepts the beat
- out_data  output  DATA_W  main register data
- out_ctrl  output  CTRL_W  main register control
- occupancy  output  2  number of held beats (0..2)

Behaviour:
- Single clock domain. Reset is synchronous and active-high; it is sampled on the rising edge of clk.
- Definitions: in_fire = in_valid & in_ready; out_fire = out_valid & out_ready.
- State machine has three states:
  - EMPTY: occupancy 0.
  - FULL: main register valid, occupancy 1.
  - SKID: main and skid registers valid, occupancy 2.
- Outputs: in_ready = (state != SKID), driven from a flop. out_valid = (state != EMPTY).
- Reset values: state EMPTY, out_valid 0, in_ready 1, out_data NOP_DATA, out_ctrl 0, skid contents NOP_DATA/0, occupancy 0.
- Latency: a beat accepted on edge N appears on out_* after edge N (one cycle) when the stage was EMPTY, or when it was FULL with out_fire.
- Transitions (priority: reset > flush > normal):
  - EMPTY, in_fire -> FULL; main <= in.
  - EMPTY, no in_fire -> stay; main holds NOP_DATA/0.
  - FULL, in_fire & out_fire -> FULL; main <= in.
  - FULL, in_fire & !out_fire -> SKID; skid <= in; main holds.
  - FULL, !in_fire & out_fire -> EMPTY; main <= NOP_DATA/0.
  - FULL, neither -> hold.
  - SKID, out_fire -> FULL; main <= skid; skid <= NOP_DATA/0.
  - SKID, no out_fire -> hold. No in_fire is possible because in_ready = 0.
- Flush, from any state -> EMPTY:
  - main and skid <= NOP_DATA/0; in_ready = 1 on the next cycle.
  - A beat that fires on in_* in the flush cycle is consumed and discarded.
  - A beat that fires on out_* in the flush cycle counts as delivered.
- Data/ctrl stability: while out_valid & !out_ready, out_data and out_ctrl hold constant.
- Whenever out_valid = 0, out_data = NOP_DATA and out_ctrl = 0, so downstream logic that ignores valid sees a bubble.
- No beat is ever dropped or duplicated except by flush.
- occupancy is derived from state and is exact every cycle.
- Reset asserted mid-operation overrides flush and handshake; the beats it discards are lost.
- reset and flush asserted together behave as reset.

Decomposition:
- Shared package pipe_pkg holds:
  - typedef enum logic [1:0] {ST_EMPTY, ST_FULL, ST_SKID} pipe_state_t;
  - localparam NOP_INSTR = 32'hD503201F;
  - localparam CTRL_NOP = '0.
- Sub-module pipe_data_reg: a width-parametrised register with load enable and synchronous clear-to-constant (reset/flush value as a parameter).
- pipe_data_reg is instantiated four times: main data, main ctrl, skid data, skid ctrl.
- The FSM and handshake logic stay in pipe_stage_skid.

Test Plan:
- Reset for 2 cycles, then release -> out_valid = 0, in_ready = 1, out_data = 32'hD503201F, out_ctrl = 0, occupancy = 0.
- in_valid = 1, in_data = 32'h8B020020, in_ctrl = 11'h458, out_ready = 1 held -> after one edge out_valid = 1 with the same values; streaming 10 beats back-to-back yields 10 outputs in order, in_ready constantly 1.
- out_ready = 0 with beats A = 32'h1, then B = 32'h2 offered -> occupancy goes 1 then 2, in_ready = 0 while out stays A. Raise out_ready -> A then B delivered on consecutive cycles, in_ready back to 1 one cycle after A leaves.
- Stage in SKID (A, B held) and flush = 1 for one cycle -> next cycle out_valid = 0, out_data = NOP, out_ctrl = 0, occupancy = 0, in_ready = 1; neither A nor B is ever emitted.
- Flush in the same cycle as in_fire of C = 32'h3 -> C is never emitted. The next beat D = 32'h4 after flush appears with one-cycle latency.
- Reset asserted while FULL with out_ready = 0 and flush = 1 -> all reset values on the next cycle; deasserting reset restores normal operation.

Source files
------------

// File: rtl/pipe_pkg.sv
// Shared types and constants for the pipeline stage registers.
package pipe_pkg;

    typedef enum logic [1:0] {
        ST_EMPTY,
        ST_FULL,
        ST_SKID
    } pipe_state_t;

    // Architectural NOP used as the bubble word.
    localparam logic [31:0] NOP_INSTR = 32'hD503201F;

    // A bubble carries no control actions.
    localparam logic [31:0] CTRL_NOP = '0;

    // Number of beats held by the stage in a given state.
    function automatic logic [1:0] state_occupancy(input pipe_state_t s);
        logic [1:0] occ;
        occ = 2'd0;
        case (s)
            ST_FULL: occ = 2'd1;
            ST_SKID: occ = 2'd2;
            default: occ = 2'd0;
        endcase
        return occ;
    endfunction

endpackage

// File: rtl/pipe_data_reg.sv
// Width-parametrised register with load enable and synchronous clear to a constant.
module pipe_data_reg #(
    parameter int unsigned     W       = 32,
    parameter logic [W-1:0]    CLR_VAL = '0
) (
    input  logic         clk,
    input  logic         i_clr,
    input  logic         i_load,
    input  logic [W-1:0] i_d,
    output logic [W-1:0] o_q
);

    logic [W-1:0] r_q;

    // Clear wins over load so reset/flush always leave a bubble behind.
    always_ff @(posedge clk) begin
        // NOTE: state is written with non-blocking assignments so every flop
        // samples pre-edge values regardless of process ordering.
        if (i_clr) begin
            r_q <= CLR_VAL;
        end else if (i_load) begin
            r_q <= i_d;
        end
    end

    assign o_q = r_q;

endmodule

// File: rtl/pipe_stage_skid.sv
// Inter-stage pipeline register with valid/ready handshake, a two-entry skid
// buffer (registered in_ready) and a synchronous flush that leaves a bubble.
module pipe_stage_skid
    import pipe_pkg::*;
#(
    parameter int unsigned  DATA_W   = 32,
    parameter int unsigned  CTRL_W   = 11,
    parameter logic [31:0]  NOP_DATA = NOP_INSTR
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic [CTRL_W-1:0] in_ctrl,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [CTRL_W-1:0] out_ctrl,
    output logic [1:0]        occupancy
);

    localparam logic [DATA_W-1:0] LP_NOP_DATA = DATA_W'(NOP_DATA);
    localparam logic [CTRL_W-1:0] LP_NOP_CTRL = CTRL_W'(CTRL_NOP);

    pipe_state_t       r_state;
    pipe_state_t       w_state_nxt;
    logic              r_in_ready;

    logic              w_in_fire;
    logic              w_out_fire;
    logic              w_main_ld;
    logic              w_main_clr;
    logic              w_main_from_skid;
    logic              w_skid_ld;
    logic              w_skid_clr;

    logic [DATA_W-1:0] w_main_data_d;
    logic [CTRL_W-1:0] w_main_ctrl_d;
    logic [DATA_W-1:0] w_main_data_q;
    logic [CTRL_W-1:0] w_main_ctrl_q;
    logic [DATA_W-1:0] w_skid_data_q;
    logic [CTRL_W-1:0] w_skid_ctrl_q;

    assign w_in_fire  = in_valid & r_in_ready;
    assign w_out_fire = out_valid & out_ready;

    // Next-state and datapath enables; reset and flush both empty the stage.
    always_comb begin
        // NOTE: every output of this block gets a default first so no path
        // through the case leaves a signal unassigned (which would infer a latch).
        w_state_nxt      = r_state;
        w_main_ld        = 1'b0;
        w_main_clr       = 1'b0;
        w_main_from_skid = 1'b0;
        w_skid_ld        = 1'b0;
        w_skid_clr       = 1'b0;

        if (reset || flush) begin
            w_state_nxt = ST_EMPTY;
            w_main_clr  = 1'b1;
            w_skid_clr  = 1'b1;
        end else begin
            case (r_state)
                ST_EMPTY: begin
                    if (w_in_fire) begin
                        w_state_nxt = ST_FULL;
                        w_main_ld   = 1'b1;
                    end
                end
                ST_FULL: begin
                    if (w_in_fire && w_out_fire) begin
                        w_main_ld = 1'b1;
                    end else if (w_in_fire) begin
                        w_state_nxt = ST_SKID;
                        w_skid_ld   = 1'b1;
                    end else if (w_out_fire) begin
                        w_state_nxt = ST_EMPTY;
                        w_main_clr  = 1'b1;
                    end
                end
                ST_SKID: begin
                    if (w_out_fire) begin
                        w_state_nxt      = ST_FULL;
                        w_main_ld        = 1'b1;
                        w_main_from_skid = 1'b1;
                        w_skid_clr       = 1'b1;
                    end
                end
                default: begin
                    w_state_nxt = ST_EMPTY;
                    w_main_clr  = 1'b1;
                    w_skid_clr  = 1'b1;
                end
            endcase
        end
    end

    // State register and registered in_ready, which looks one state ahead.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= ST_EMPTY;
            r_in_ready <= 1'b1;
        end else begin
            r_state    <= w_state_nxt;
            r_in_ready <= (w_state_nxt != ST_SKID);
        end
    end

    // The main register refills from the skid entry when draining SKID.
    always_comb begin
        w_main_data_d = w_main_from_skid ? w_skid_data_q : in_data;
        w_main_ctrl_d = w_main_from_skid ? w_skid_ctrl_q : in_ctrl;
    end

    pipe_data_reg #(.W(DATA_W), .CLR_VAL(LP_NOP_DATA)) u_main_data (
        .clk    (clk),
        .i_clr  (w_main_clr),
        .i_load (w_main_ld),
        .i_d    (w_main_data_d),
        .o_q    (w_main_data_q)
    );

    pipe_data_reg #(.W(CTRL_W), .CLR_VAL(LP_NOP_CTRL)) u_main_ctrl (
        .clk    (clk),
        .i_clr  (w_main_clr),
        .i_load (w_main_ld),
        .i_d    (w_main_ctrl_d),
        .o_q    (w_main_ctrl_q)
    );

    pipe_data_reg #(.W(DATA_W), .CLR_VAL(LP_NOP_DATA)) u_skid_data (
        .clk    (clk),
        .i_clr  (w_skid_clr),
        .i_load (w_skid_ld),
        .i_d    (in_data),
        .o_q    (w_skid_data_q)
    );

    pipe_data_reg #(.W(CTRL_W), .CLR_VAL(LP_NOP_CTRL)) u_skid_ctrl (
        .clk    (clk),
        .i_clr  (w_skid_clr),
        .i_load (w_skid_ld),
        .i_d    (in_ctrl),
        .o_q    (w_skid_ctrl_q)
    );

    assign in_ready  = r_in_ready;
    assign out_valid = (r_state != ST_EMPTY);
    assign out_data  = w_main_data_q;
    assign out_ctrl  = w_main_ctrl_q;
    assign occupancy = state_occupancy(r_state);

endmodule

// File: tb/tb_pipe_stage_skid.sv
// Self-checking bench for pipe_stage_skid: a queue-based model of the held
// beats checked every cycle, plus directed scenarios with literal expectations.
module tb_pipe_stage_skid;

    localparam logic [31:0] NOP = 32'hD503201F;

    logic        clk;
    logic        reset;
    logic        flush;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_data;
    logic [10:0] in_ctrl;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_data;
    logic [10:0] out_ctrl;
    logic [1:0]  occupancy;

    int n_checks = 0;
    int n_errors = 0;

    typedef struct {
        logic [31:0] d;
        logic [10:0] c;
    } beat_t;

    beat_t       m_q[$];
    logic        m_ready    = 1'b1;
    logic        model_live = 1'b0;
    logic [31:0] dut_log[$];

    pipe_stage_skid dut (
        .clk       (clk),
        .reset     (reset),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_ctrl   (in_ctrl),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_ctrl  (out_ctrl),
        .occupancy (occupancy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    // Model: the stage is a FIFO of at most two beats; in_ready reflects
    // whether there was room after the previous edge.
    always @(posedge clk) begin
        logic m_in_fire;
        logic m_out_fire;
        if (out_valid === 1'b1 && out_ready === 1'b1) dut_log.push_back(out_data);
        m_out_fire = (m_q.size() > 0) && out_ready;
        m_in_fire  = in_valid && m_ready;
        if (reset || flush) begin
            m_q.delete();
            m_ready = 1'b1;
        end else begin
            if (m_out_fire) void'(m_q.pop_front());
            if (m_in_fire) m_q.push_back('{d: in_data, c: in_ctrl});
            m_ready = (m_q.size() < 2);
        end
        model_live = 1'b1;
    end

    // Per-cycle comparison against the model, on the falling edge.
    always @(negedge clk) begin
        if (model_live) begin
            check("cyc_out_valid", 64'(out_valid), 64'(m_q.size() > 0));
            check("cyc_out_data",  64'(out_data),  64'((m_q.size() > 0) ? m_q[0].d : NOP));
            check("cyc_out_ctrl",  64'(out_ctrl),  64'((m_q.size() > 0) ? m_q[0].c : 11'h0));
            check("cyc_occupancy", 64'(occupancy), 64'(m_q.size()));
            check("cyc_in_ready",  64'(in_ready),  64'(m_ready));
        end
    end

    function automatic logic [31:0] log_at(input int i);
        return (i < dut_log.size()) ? dut_log[i] : 32'hxxxxxxxx;
    endfunction

    task automatic check_reset_values(input string tag);
        check({tag, "_out_valid"}, 64'(out_valid), 64'd0);
        check({tag, "_in_ready"},  64'(in_ready),  64'd1);
        check({tag, "_out_data"},  64'(out_data),  64'(NOP));
        check({tag, "_out_ctrl"},  64'(out_ctrl),  64'd0);
        check({tag, "_occupancy"}, 64'(occupancy), 64'd0);
    endtask

    initial begin
        reset     = 1'b1;
        flush     = 1'b0;
        in_valid  = 1'b0;
        in_data   = '0;
        in_ctrl   = '0;
        out_ready = 1'b0;

        // Reset for two cycles, then release.
        repeat (2) cycle();
        check_reset_values("rst");
        reset = 1'b0;
        cycle();
        check_reset_values("rst_rel");

        // First beat with one-cycle latency, then 10 back-to-back beats.
        dut_log.delete();
        in_valid  = 1'b1;
        in_data   = 32'h8B020020;
        in_ctrl   = 11'h458;
        out_ready = 1'b1;
        cycle();
        check("first_valid", 64'(out_valid), 64'd1);
        check("first_data",  64'(out_data),  64'h8B020020);
        check("first_ctrl",  64'(out_ctrl),  64'h458);
        for (int i = 0; i < 10; i++) begin
            in_data = 32'h100 + 32'(i);
            in_ctrl = 11'(i);
            cycle();
            check("stream_in_ready", 64'(in_ready), 64'd1);
        end
        in_valid = 1'b0;
        cycle();
        check("stream_len", 64'(dut_log.size()), 64'd11);
        check("stream_0", 64'(log_at(0)), 64'h8B020020);
        for (int i = 1; i < 11; i++) check("stream_n", 64'(log_at(i)), 64'(32'h100 + 32'(i - 1)));

        // Back-pressure into the skid entry, then drain.
        dut_log.delete();
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_data   = 32'h1;
        in_ctrl   = 11'h1;
        cycle();
        check("skid_occ1", 64'(occupancy), 64'd1);
        in_data = 32'h2;
        in_ctrl = 11'h2;
        cycle();
        check("skid_occ2",   64'(occupancy), 64'd2);
        check("skid_ready0", 64'(in_ready),  64'd0);
        check("skid_outA",   64'(out_data),  64'h1);
        in_valid = 1'b0;
        cycle();
        check("skid_hold_A",   64'(out_data), 64'h1);
        check("skid_hold_occ", 64'(occupancy), 64'd2);
        out_ready = 1'b1;
        cycle();
        check("drain_outB",   64'(out_data), 64'h2);
        check("drain_ready1", 64'(in_ready), 64'd1);
        check("drain_occ1",   64'(occupancy), 64'd1);
        cycle();
        check("drain_empty", 64'(out_valid), 64'd0);
        check("drain_len",   64'(dut_log.size()), 64'd2);
        check("drain_0",     64'(log_at(0)), 64'h1);
        check("drain_1",     64'(log_at(1)), 64'h2);

        // Flush while in SKID: neither held beat is ever emitted.
        dut_log.delete();
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_data   = 32'h11;
        cycle();
        in_data = 32'h12;
        cycle();
        in_valid = 1'b0;
        check("fl_skid_occ", 64'(occupancy), 64'd2);
        flush = 1'b1;
        cycle();
        flush = 1'b0;
        check_reset_values("fl_skid");
        out_ready = 1'b1;
        repeat (3) cycle();
        check("fl_skid_none", 64'(dut_log.size()), 64'd0);

        // Flush coincident with in_fire of C; D follows with one-cycle latency.
        dut_log.delete();
        in_valid = 1'b1;
        in_data  = 32'h3;
        in_ctrl  = 11'h3;
        flush    = 1'b1;
        cycle();
        flush   = 1'b0;
        check("fl_in_empty", 64'(out_valid), 64'd0);
        in_data = 32'h4;
        in_ctrl = 11'h4;
        cycle();
        check("fl_in_D_valid", 64'(out_valid), 64'd1);
        check("fl_in_D_data",  64'(out_data),  64'h4);
        in_valid = 1'b0;
        cycle();
        check("fl_in_len", 64'(dut_log.size()), 64'd1);
        check("fl_in_0",   64'(log_at(0)), 64'h4);

        // Reset together with flush while FULL and stalled.
        dut_log.delete();
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_data   = 32'h5;
        cycle();
        in_valid = 1'b0;
        check("rst_full_occ", 64'(occupancy), 64'd1);
        reset = 1'b1;
        flush = 1'b1;
        cycle();
        check_reset_values("rst_mid");
        reset     = 1'b0;
        flush     = 1'b0;
        in_valid  = 1'b1;
        in_data   = 32'h6;
        in_ctrl   = 11'h6;
        out_ready = 1'b1;
        cycle();
        check("rst_after_data", 64'(out_data), 64'h6);
        in_valid = 1'b0;
        cycle();
        check("rst_after_len", 64'(dut_log.size()), 64'd1);
        check("rst_after_0",   64'(log_at(0)), 64'h6);

        // Mixed traffic with irregular back-pressure and one flush.
        for (int i = 0; i < 48; i++) begin
            in_valid  = (i % 3) != 0;
            in_data   = 32'hA000 + 32'(i);
            in_ctrl   = 11'(i * 7);
            out_ready = ((i / 2) % 3) == 1 || (i % 5) == 0;
            flush     = (i == 29);
            cycle();
        end
        flush     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        repeat (4) cycle();
        check("mix_drained", 64'(occupancy), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
